// File: rtl/fx2_pkg.sv
// Shared state encodings, defaults and width helper for the FX2 slave-FIFO writer.
package fx2_pkg;

    localparam int FX2_W          = 8;
    localparam int FX2_PKT_WORDS  = 512;
    localparam int FX2_PKTEND_GAP = 4;
    localparam int FX2_TIMEOUT    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_PKTEND = 2'd2,
        ST_GAP    = 2'd3
    } fx2_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int fx2_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fx2_idle_timer.sv
// Saturating idle counter with synchronous clear, count enable and terminal-count flag.
module fx2_idle_timer
    import fx2_pkg::*;
#(
    parameter int TERMINAL = FX2_TIMEOUT
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = fx2_width(TERMINAL);
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc_o = (r_count == LAST);

endmodule

// File: rtl/fx2_fifo_writer.sv
// Drains the CDC synchronizer into the FX2 slave FIFO and commits short packets with PKTEND.
// Define TIMEOUT_FLUSH_EN to build the idle timer that flushes a stale partial packet.
module fx2_fifo_writer
    import fx2_pkg::*;
#(
    parameter int W          = FX2_W,
    parameter int PKT_WORDS  = FX2_PKT_WORDS,
    parameter int TIMEOUT    = FX2_TIMEOUT,
    parameter int PKTEND_GAP = FX2_PKTEND_GAP
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_rd_o,
    output logic [W-1:0] ext_data_o,
    output logic         ext_wr_n_o,
    output logic         ext_pktend_n_o,
    input  logic         ext_full_n_i,
    input  logic         flush_i,
    output logic         busy_o
);

    localparam int CW = $clog2(PKT_WORDS + 1);
    localparam int GW = fx2_width(PKTEND_GAP);
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(PKTEND_GAP - 1);

    fx2_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic          r_full_n_q;
    logic          r_flush_pend;
    logic [W-1:0]  r_data;
    logic          r_wr_n;
    logic          r_pktend_n;

    logic w_accepting;
    logic w_consume;
    logic w_pending;
    logic w_pktend_fire;
    logic w_timeout;
    logic w_flush_req;

    assign w_accepting   = (r_state == ST_IDLE) || (r_state == ST_WRITE);
    assign in_rd_o       = in_valid_i & r_full_n_q & ~r_flush_pend & w_accepting;
    assign w_consume     = in_rd_o & in_valid_i;
    assign w_pending     = (r_cnt != '0);
    assign w_pktend_fire = (r_state == ST_PKTEND) & r_full_n_q;
    assign w_flush_req   = flush_i | w_timeout;

`ifdef TIMEOUT_FLUSH_EN
    logic w_tc;

    fx2_idle_timer #(
        .TERMINAL (TIMEOUT)
    ) u_idle_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr_i     (w_consume | w_pktend_fire),
        .en_i      (w_pending & ~w_consume),
        .tc_o      (w_tc)
    );

    assign w_timeout = w_tc & w_pending & w_accepting;
`else
    // No idle timer in this build; the comparison only keeps TIMEOUT referenced.
    assign w_timeout = (TIMEOUT < 0);
`endif

    // A flush raised while idle/writing is resolved one cycle later, after any
    // coincident write has been counted, so that word lands in the packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_full_n_q   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_data       <= '0;
            r_wr_n       <= 1'b1;
            r_pktend_n   <= 1'b1;
        end else begin
            r_full_n_q <= ext_full_n_i;
            r_wr_n     <= ~w_consume;
            r_pktend_n <= 1'b1;

            if (w_consume) begin
                r_data <= in_data_i;
                r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (r_flush_pend) begin
                        if (w_pending) begin
                            r_state <= ST_PKTEND;
                        end else begin
                            r_flush_pend <= 1'b0;
                            r_state      <= ST_IDLE;
                        end
                    end else begin
                        if (w_flush_req) begin
                            r_flush_pend <= 1'b1;
                        end
                        if (w_consume) begin
                            r_state <= ST_WRITE;
                        end else if (!w_pending) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_PKTEND: begin
                    if (r_full_n_q) begin
                        r_pktend_n   <= 1'b0;
                        r_cnt        <= '0;
                        r_flush_pend <= 1'b0;
                        r_gap        <= '0;
                        r_state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ext_data_o     = r_data;
    assign ext_wr_n_o     = r_wr_n;
    assign ext_pktend_n_o = r_pktend_n;
    assign busy_o         = (r_state != ST_IDLE) | w_pending;

endmodule
